// File: rtl/multiword_rca_sequencer.sv
// Multi-precision adder built around one 16-bit ripple-carry stage.
// A WORDS*16-bit sum is formed one 16-bit slice per clock, least-significant
// slice first. The carry between slices is held in a register, so the
// combinational path is never longer than a single 16-bit ripple chain.

// 16-bit ripple-carry adder: a chain of gate-level full adders.
module RCA_16_bit (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        carry_in,
    output logic [15:0] sum,
    output logic        carry_out
);

    logic [16:0] w_c;

    assign w_c[0] = carry_in;

    for (genvar i = 0; i < 16; i++) begin : g_fa
        assign sum[i]     = x[i] ^ y[i] ^ w_c[i];
        assign w_c[i + 1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end

    assign carry_out = w_c[16];

endmodule

module multiword_rca_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WORDS*16-1:0]  x,
    input  logic [WORDS*16-1:0]  y,
    input  logic                 carry_in,
    output logic [WORDS*16-1:0]  sum,
    output logic                 carry_out,
    output logic                 overflow,
    output logic                 busy,
    output logic                 done
);

    localparam int W     = WORDS * 16;
    localparam int IDX_W = $clog2(WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [IDX_W-1:0]   r_idx;
    logic               r_c;
    logic [W-1:0]       r_x;
    logic [W-1:0]       r_y;
    logic [W-1:0]       r_sum;
    logic               r_carry_out;
    logic               r_overflow;
    logic               r_busy;
    logic               r_done;

    // Slice base is idx*16; built by concatenation so the index expression
    // is wide enough to address every bit of the operand.
    logic [IDX_W+3:0]   w_base;
    logic               w_last;
    logic [15:0]        w_x_slice;
    logic [15:0]        w_y_slice;
    logic [15:0]        w_rca_sum;
    logic               w_rca_cout;

    assign w_base    = {r_idx, 4'b0000};
    assign w_last    = (r_idx == IDX_W'(WORDS - 1));
    assign w_x_slice = r_x[w_base +: 16];
    assign w_y_slice = r_y[w_base +: 16];

    RCA_16_bit u_rca (
        .x         (w_x_slice),
        .y         (w_y_slice),
        .carry_in  (r_c),
        .sum       (w_rca_sum),
        .carry_out (w_rca_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every
        // register in the design samples pre-edge values consistently.
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: IDLE -> ADD on start, ADD -> DONE after the top slice.
    always_comb begin
        // NOTE: default first, so no path through the case leaves the
        // variable unassigned and infers a latch.
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_ADD;
            S_ADD:   if (w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: operand capture, per-slice accumulation and status flags.
    always_ff @(posedge clk) begin
        // NOTE: the operand registers are plain flops, not a memory array,
        // so they are cleared together with the rest of the state.
        if (!rst_n) begin
            r_idx       <= '0;
            r_c         <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x         <= x;
                        r_y         <= y;
                        r_c         <= carry_in;
                        r_idx       <= '0;
                        r_sum       <= '0;
                        r_carry_out <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                S_ADD: begin
                    r_sum[w_base +: 16] <= w_rca_sum;
                    r_c                 <= w_rca_cout;
                    r_idx               <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_carry_out <= w_rca_cout;
                        r_overflow  <= (r_x[W-1] ~^ r_y[W-1]) & (r_x[W-1] ^ w_rca_sum[15]);
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b0;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_multiword_rca_sequencer.sv
// Bench for multiword_rca_sequencer (WORDS=4). Expected results come from
// plain wide arithmetic on the operands; timing is checked cycle by cycle.
module tb_multiword_rca_sequencer;

    localparam int WORDS = 4;
    localparam int W     = WORDS * 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic          carry_in;
    logic [W-1:0]  sum;
    logic          carry_out;
    logic          overflow;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    multiword_rca_sequencer #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x         (x),
        .y         (y),
        .carry_in  (carry_in),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] v;
        v = {$urandom, $urandom};
        return v;
    endfunction

    // One addition: drive start at a negedge, then watch every cycle.
    // With inject set, a second start with all-ones operands is raised so
    // that it is sampled two edges after the accepted one.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input bit inject);
        logic [W:0]   full;
        logic [W-1:0] exp_sum;
        logic         exp_c;
        logic         exp_ov;
        int           busy_cnt;
        int           done_cnt;
        int           done_at;

        full    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        exp_sum = full[W-1:0];
        exp_c   = full[W];
        exp_ov  = (a[W-1] == b[W-1]) && (exp_sum[W-1] != a[W-1]);

        @(negedge clk);
        x        = a;
        y        = b;
        carry_in = ci;
        start    = 1'b1;
        @(negedge clk);
        // Accepted edge has passed; scramble inputs to prove they are unused.
        start    = 1'b0;
        x        = rand_word();
        y        = rand_word();
        carry_in = ~ci;

        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        for (int j = 0; j < WORDS + 4; j++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = j;
            end
            if (j == WORDS) begin
                check({name, " done_at_latency"}, W'(done), W'(1));
                check({name, " sum"},             sum,       exp_sum);
                check({name, " carry_out"},       W'(carry_out), W'(exp_c));
                check({name, " overflow"},        W'(overflow),  W'(exp_ov));
            end
            if (inject && j == 1) begin
                start = 1'b1;
                x     = '1;
                y     = '1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check({name, " busy_cycles"}, W'(busy_cnt), W'(WORDS));
        check({name, " done_pulses"}, W'(done_cnt), W'(1));
        check({name, " done_index"},  W'(done_at),  W'(WORDS));
        check({name, " sum_held"},    sum,          exp_sum);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b1;
        x        = '1;
        y        = '1;
        carry_in = 1'b1;

        // Reset held for two edges with start asserted.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst sum",       sum,             '0);
        check("rst carry_out", W'(carry_out),   '0);
        check("rst overflow",  W'(overflow),    '0);
        check("rst busy",      W'(busy),        '0);
        check("rst done",      W'(done),        '0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst idle busy", W'(busy), '0);

        run_op("slice_carry", 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
        run_op("full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        run_op("signed_ovf",  64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
        run_op("neg_ovf",     64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        run_op("ignored_start", 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0003, 1'b0, 1'b1);

        // Reset in the middle of an operation, on the edge that processes idx=2.
        @(negedge clk);
        x        = 64'hFFFF_FFFF_FFFF_FFFF;
        y        = 64'h0000_0000_0000_0001;
        carry_in = 1'b0;
        start    = 1'b1;
        @(negedge clk);             // start edge k passed, idx=0
        start = 1'b0;
        @(negedge clk);             // edge k+1 passed, idx=1
        @(negedge clk);             // edge k+2 passed, idx=2
        check("midop busy_before_rst", W'(busy), W'(1));
        rst_n = 1'b0;
        @(negedge clk);             // reset sampled at edge k+3
        check("midop_rst sum",       sum,           '0);
        check("midop_rst carry_out", W'(carry_out), '0);
        check("midop_rst overflow",  W'(overflow),  '0);
        check("midop_rst busy",      W'(busy),      '0);
        check("midop_rst done",      W'(done),      '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midop_rst stays_idle busy", W'(busy), '0);
        check("midop_rst stays_idle done", W'(done), '0);

        run_op("after_rst", 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0003, 1'b1, 1'b0);

        for (int n = 0; n < 8; n++) begin
            run_op($sformatf("rand%0d", n), rand_word(), rand_word(), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
